lut_neuron_prog: RTL and testbench
==================================

Name: lut_neuron_prog

Overview:
- Runtime-programmable truth-table neuron: a writer-side counterpart to the fixed ROM neurons produced by the generator.
- A config stream loads a 2^IN_BITS x OUT_BITS table into distributed RAM. Lookups are then served through a valid/ready pipeline.
- Used in layer-level test harnesses and for in-field retargeting of a neuron without resynthesis.

Parameters:
- IN_BITS, 8, lookup address width; table depth DEPTH = 2^IN_BITS.
- OUT_BITS, 2, width of each table entry.
- CFG_W, 8, config beat width; must be a multiple of OUT_BITS. EPB = CFG_W/OUT_BITS entries per beat. NBEATS = DEPTH/EPB (64 at defaults).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accepted when cfg_valid && cfg_ready.
- cfg_data  in  CFG_W  packed entries: entry EPB*k+j sits at bits [OUT_BITS*j +: OUT_BITS] of beat k.
- cfg_last  in  1  marks the final beat of a load.
- cfg_done  out  1  one-cycle pulse when a load completes correctly.
- cfg_err  out  1  one-cycle pulse when a framing error is detected.
- table_ok  out  1  high while a valid table is held.
- in_valid  in  1  lookup request.
- in_ready  out  1  lookup accepted when in_valid && in_ready.
- in_data  in  IN_BITS  lookup address.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  OUT_BITS  table[in_data].

Behaviour:
- Reset (async assert, sync deassert inside block):
  - state=EMPTY, beat counter=0.
  - out_valid=0, out_data=0, cfg_done=0, cfg_err=0, table_ok=0, cfg_ready=0, in_ready=0.
  - RAM contents are not reset.
- States: EMPTY, LOAD, DRAIN, ACTIVE.
- EMPTY:
  - cfg_ready=1, in_ready=0.
  - The first accepted beat is beat 0; go to LOAD (or finish immediately if NBEATS=1).
- LOAD:
  - cfg_ready=1. Each accepted beat writes EPB entries at base EPB*cnt, then cnt increments.
  - Accepted beat with cnt==NBEATS-1 and cfg_last=1: cfg_done pulses next cycle, table_ok=1, cnt=0, state=ACTIVE.
  - Accepted beat with cnt==NBEATS-1 and cfg_last=0: the beat is written, cfg_err pulses, table_ok=0, state=DRAIN.
  - Accepted beat with cnt<NBEATS-1 and cfg_last=1 (early last): the beat is written, cfg_err pulses, table_ok=0, cnt=0, state=EMPTY.
- DRAIN:
  - cfg_ready=1; beats are discarded with no RAM write.
  - Accepted beat with cfg_last=1: cnt=0, state=EMPTY. No second cfg_err.
- ACTIVE, lookup path:
  - in_ready = !cfg_valid && (!out_valid || out_ready).
  - Accepted request: out_data<=RAM[in_data] and out_valid<=1 on the next edge (latency 1). Full throughput with out_ready held high.
  - out_valid && !out_ready: out_data holds stable and in_ready=0.
  - out_valid clears on consume when no new request is accepted in the same cycle.
- ACTIVE, reload:
  - Config has priority. While cfg_valid=1, in_ready=0.
  - cfg_ready = cfg_valid && !out_valid, so a pending result must be consumed first.
  - The first accepted beat clears table_ok the same edge, is written as beat 0, and moves the block to LOAD.
- No read-during-write: lookups are impossible outside ACTIVE, and ACTIVE never writes.
- Reset mid-load: returns to EMPTY with table_ok=0. Partial RAM contents are considered invalid.
- cfg_done and cfg_err are never asserted in the same cycle.

Test Plan:
- Load / readback:
  - Reset, load 64 beats of 8'hE4 with cfg_last on beat 63.
  - Expect cfg_done one pulse, table_ok=1.
  - Lookups 8'hC7, 8'h00, 8'h5A return 2'b11, 2'b00, 2'b10, one cycle after accept, back-to-back with out_ready=1.
- Backpressure:
  - After load, hold out_ready=0 with in_valid=1 and in_data=8'h01.
  - Expect out_valid=1, out_data=2'b01 held stable, in_ready=0.
  - Release out_ready: next result 2'b01 follows with no loss or duplication.
- Early last:
  - Assert cfg_last on beat 10.
  - Expect cfg_err one pulse, table_ok=0, in_ready=0, state EMPTY; a subsequent correct 64-beat load succeeds.
- Missing last:
  - 64 beats with no last, then 3 extra beats, the third carrying cfg_last.
  - Expect a single cfg_err pulse, extra beats discarded, then a full load of 8'h1B gives lookup 8'h03 -> 2'b00 and 8'h00 -> 2'b11.
- Reload while active:
  - out_valid pending with out_ready=0; assert cfg_valid.
  - Expect cfg_ready=0 until the result is consumed, then table_ok drops on the first beat and the new table is served after cfg_done.
- Reset mid-load:
  - Assert rst_n=0 at beat 30.
  - Expect all outputs at reset values immediately (asynchronous) and table_ok=0 after release.

Source files
------------

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable truth-table neuron: a config stream loads a 2^IN_BITS x OUT_BITS
// table into distributed RAM, and lookups are then served through a valid/ready pipeline.
module lut_neuron_prog #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2,
    parameter int unsigned CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    input  logic                cfg_last,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                table_ok,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int unsigned DEPTH  = 1 << IN_BITS;
    localparam int unsigned EPB    = CFG_W / OUT_BITS;
    localparam int unsigned NBEATS = DEPTH / EPB;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_DRAIN,
        S_ACTIVE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                table_ok_q, table_ok_d;
    logic                cfg_done_q, cfg_done_d;
    logic                cfg_err_q, cfg_err_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                live_q, live_d;

    logic                cfg_acc_c;
    logic                in_acc_c;
    logic                wr_en_c;
    logic                last_beat_c;
    logic [IN_BITS-1:0]  wr_base_c;

    logic [OUT_BITS-1:0] mem [DEPTH];

    // Handshakes stay low until the first edge after reset release.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        table_ok_d  = table_ok_q;
        cfg_done_d  = 1'b0;
        cfg_err_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        live_d      = 1'b1;
        cfg_ready   = 1'b0;
        in_ready    = 1'b0;

        if (live_q) begin
            if (state_q == S_ACTIVE) begin
                cfg_ready = cfg_valid && !out_valid_q;
                in_ready  = !cfg_valid && (!out_valid_q || out_ready);
            end else begin
                cfg_ready = 1'b1;
            end
        end

        cfg_acc_c   = cfg_valid && cfg_ready;
        in_acc_c    = in_valid && in_ready;
        wr_en_c     = cfg_acc_c && (state_q != S_DRAIN);
        last_beat_c = (cnt_q == CNT_W'(NBEATS - 1));
        wr_base_c   = IN_BITS'(32'(cnt_q) * EPB);

        // Config framing: DRAIN swallows beats until the terminating last.
        if (cfg_acc_c) begin
            if (state_q == S_DRAIN) begin
                if (cfg_last) begin
                    state_d = S_EMPTY;
                    cnt_d   = '0;
                end
            end else begin
                table_ok_d = 1'b0;
                if (last_beat_c) begin
                    cnt_d = '0;
                    if (cfg_last) begin
                        cfg_done_d = 1'b1;
                        table_ok_d = 1'b1;
                        state_d    = S_ACTIVE;
                    end else begin
                        cfg_err_d = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end else if (cfg_last) begin
                    cfg_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_EMPTY;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_LOAD;
                end
            end
        end

        if (in_acc_c) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[in_data];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            cnt_q       <= '0;
            table_ok_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            table_ok_q  <= table_ok_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            live_q      <= live_d;
        end
    end

    // Table storage is deliberately not reset; table_ok qualifies its contents.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int unsigned j = 0; j < EPB; j++) begin
                mem[wr_base_c + IN_BITS'(j)] <= cfg_data[OUT_BITS*j +: OUT_BITS];
            end
        end
    end

    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign table_ok  = table_ok_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Self-checking bench for lut_neuron_prog: directed framing scenarios plus randomized
// tables and lookup traffic, checked against a load-level behavioural model.
module tb_lut_neuron_prog;

    localparam int NB = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_data = '0;
    logic       cfg_last = 1'b0;
    logic       cfg_done;
    logic       cfg_err;
    logic       table_ok;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: committed table, validity, beats of the load in progress.
    logic [1:0] m_tbl [256];
    bit         m_ok    = 1'b0;
    bit         m_drain = 1'b0;
    logic [7:0] m_q [$];

    lut_neuron_prog dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .table_ok  (table_ok),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ok    = 1'b0;
        m_drain = 1'b0;
        m_q.delete();
    endtask

    // A load commits only when exactly NB beats arrive with last on the final one.
    task automatic model_beat(input logic [7:0] d, input bit l, output bit ed, output bit ee);
        logic [7:0] b;
        ed = 1'b0;
        ee = 1'b0;
        if (m_drain) begin
            if (l) m_drain = 1'b0;
        end else begin
            m_q.push_back(d);
            m_ok = 1'b0;
            if (m_q.size() == NB) begin
                if (l) begin
                    ed   = 1'b1;
                    m_ok = 1'b1;
                    for (int k = 0; k < NB; k++) begin
                        b = m_q[k];
                        for (int j = 0; j < 4; j++) m_tbl[4*k + j] = b[2*j +: 2];
                    end
                end else begin
                    ee      = 1'b1;
                    m_drain = 1'b1;
                end
                m_q.delete();
            end else if (l) begin
                ee = 1'b1;
                m_q.delete();
            end
        end
    endtask

    // Presents one beat, waits (bounded) for acceptance, then checks the status outputs.
    task automatic send_beat(input logic [7:0] d, input bit l);
        int n;
        bit ed, ee;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        #1;
        n = 0;
        while (!cfg_ready && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!cfg_ready) begin
            chk("cfg_timeout", cfg_ready, 1);
        end else begin
            @(posedge clk);
            model_beat(d, l, ed, ee);
            #1;
            chk("cfg_done", cfg_done, ed);
            chk("cfg_err", cfg_err, ee);
            chk("table_ok", table_ok, m_ok);
        end
    endtask

    task automatic load(input logic [7:0] pat, input bit rnd, input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) begin
            send_beat(rnd ? 8'($urandom) : pat, k == last_at);
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("pulse_done_1cyc", cfg_done, 0);
        chk("pulse_err_1cyc", cfg_err, 0);
    endtask

    // Back-to-back lookup with out_ready high; leaves in_valid asserted.
    task automatic lookup(input logic [7:0] a);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = a;
        #1;
        chk("lk_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("lk_out_valid", out_valid, 1);
        chk("lk_out_data", out_data, m_tbl[a]);
    endtask

    task automatic lookup_end();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("lk_idle", out_valid, 0);
    endtask

    // Random request/consume traffic checked through an expected-result queue.
    task automatic rand_traffic(input int ncyc);
        logic [1:0] exp_q [$];
        bit acc_in, acc_out;
        for (int c = 0; c < ncyc; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rand_in_ready", in_ready, !out_valid || out_ready);
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("rand_spurious", out_valid, 0);
                else chk("rand_out", out_data, exp_q[0]);
            end
            if (acc_out && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc_in) exp_q.push_back(m_tbl[in_data]);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid && exp_q.size() > 0) begin
            chk("rand_tail", out_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        chk("rand_left", exp_q.size(), 0);
        chk("rand_drained", out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_cfg_done"}, cfg_done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_table_ok"}, table_ok, 0);
    endtask

    initial begin
        logic [7:0] a;
        #1;
        check_reset_outputs("rst");
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("empty_cfg_ready", cfg_ready, 1);
        chk("empty_in_ready", in_ready, 0);

        // Load E4 pattern and read back
        load(8'hE4, 1'b0, NB, NB - 1);
        lookup(8'hC7);
        chk("lk_C7_const", out_data, 2'b11);
        lookup(8'h00);
        chk("lk_00_const", out_data, 2'b00);
        lookup(8'h5A);
        chk("lk_5A_const", out_data, 2'b10);
        lookup_end();

        // Backpressure: result held stable while the consumer stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 2'b01);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_data", out_data, 2'b01);
        @(posedge clk);
        #1;
        chk("bp_no_dup", out_valid, 0);

        // Early last on beat 10, then a good load
        load(8'h00, 1'b1, 11, 10);
        chk("early_in_ready", in_ready, 0);
        chk("early_cfg_ready", cfg_ready, 1);
        load(8'h00, 1'b1, NB, NB - 1);
        rand_traffic(200);

        // Missing last: 64 beats, then 3 extra with last on the third
        load(8'h00, 1'b1, NB + 3, NB + 2);
        chk("miss_in_ready", in_ready, 0);
        load(8'h1B, 1'b0, NB, NB - 1);
        lookup(8'h03);
        chk("miss_03_const", out_data, 2'b00);
        lookup(8'h00);
        chk("miss_00_const", out_data, 2'b11);
        lookup_end();

        // Reload while a result is pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'($urandom);
        in_data   = a;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
        cfg_last  = 1'b0;
        #1;
        chk("rl_pending", out_valid, 1);
        chk("rl_cfg_blocked", cfg_ready, 0);
        chk("rl_in_blocked", in_ready, 0);
        @(posedge clk);
        #1;
        chk("rl_cfg_blocked2", cfg_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("rl_cfg_blocked3", cfg_ready, 0);
        chk("rl_pending_data", out_data, m_tbl[a]);
        @(posedge clk);
        #1;
        chk("rl_consumed", out_valid, 0);
        chk("rl_cfg_open", cfg_ready, 1);
        chk("rl_still_ok", table_ok, 1);
        load(8'h00, 1'b1, NB, NB - 1);
        rand_traffic(300);

        // Reset during a load
        load(8'h00, 1'b1, 30, -1);
        cfg_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        #13;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_table_ok", table_ok, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        cfg_valid = 1'b0;
        load(8'h00, 1'b1, NB, NB - 1);
        rand_traffic(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
